// File: rtl/dice_pkg.sv
// Shared definitions for the electronic dice front end: debounce FSM
// state encoding and default timing constants.
package dice_pkg;

  // Debounce FSM states, shared with anything that decodes the state.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // Consecutive stable samples needed to accept a level change.
  localparam int DEFAULT_DEBOUNCE = 16;

  // Cycles held before a press counts as long (also used by dice timing).
  localparam int DEFAULT_LONG = 50_000_000;

  // Width of a counter that must reach long_cycles without wrapping.
  function automatic int cnt_width(input int long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Asynchronous active-low reset; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync0_q;
  logic [WIDTH-1:0] sync0_d;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync1_d;

  // Next values: first stage captures the input, second re-times the first.
  always_comb begin
    sync0_d = d;
    sync1_d = sync0_q;
  end

  // Synchroniser flops; only sync1_q is safe to use downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
    end
  end

  assign q = sync1_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioning: synchronise, debounce with a consecutive
// sample counter, and emit a clean level, press/release pulses and a
// long-press flag. All outputs come straight from flops.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module button_debounce
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int LONG_CYCLES     = DEFAULT_LONG
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  // One counter serves both the debounce windows and the hold timer, so it
  // is sized for the larger of the two (LONG_CYCLES > DEBOUNCE_CYCLES).
  localparam int CNT_W = cnt_width(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);

  logic sync1;

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q, button_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_press_q, long_press_d;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (sync1)
  );

  // Next-state and next-output logic for the debounce FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    button_d     = button_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = long_press_q;

    unique case (state_q)
      RELEASED: begin
        if (sync1) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync1) begin
          // Bounce: the high level did not last long enough.
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = PRESSED;
          button_d = 1'b1;
          press_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync1) begin
          // Start qualifying a release; long_press stays as it is.
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          // Hold timer saturates so a very long hold never wraps.
          if (cnt_q != LONG_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_q == LONG_PRE) begin
            long_press_d = 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync1) begin
          // Release was a bounce: back to held, no new press, timer restarts.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d      = RELEASED;
          button_d     = 1'b0;
          release_d    = 1'b1;
          long_press_d = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RELEASED;
      cnt_q        <= '0;
      button_q     <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      button_q     <= button_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
    end
  end

  assign button        = button_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce. Two instances share inputs:
// dut4 (DEBOUNCE_CYCLES=4, LONG_CYCLES=100) and dut16 (defaults).
// A monitor pops expected dut4 output events from a scoreboard queue.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_raw = 1'b0;

  logic b4, p4, r4, l4;
  logic b16, p16, r16, l16;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int kind;  // 0 press, 1 release, 2 long rise, 3 long fall
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  string kname[4] = '{"press", "release", "long_rise", "long_fall"};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(100)
  ) dut4 (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (button_raw),
    .button       (b4),
    .press        (p4),
    .release_pulse(r4),
    .long_press   (l4)
  );

  button_debounce dut16 (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (button_raw),
    .button       (b16),
    .press        (p16),
    .release_pulse(r16),
    .long_press   (l16)
  );

  // Stand-in for the dice FSM: rolls while button is high, latches on fall.
  int   die = 1;
  int   throw_v = 0;
  int   rises = 0;
  logic b4_d = 1'b0;
  always @(posedge clk) begin
    if (b4 && !b4_d) rises <= rises + 1;
    if (!b4 && b4_d) throw_v <= die;
    if (b4) die <= (die == 6) ? 1 : die + 1;
    b4_d <= b4;
  end

  // Scoreboard monitor for dut4 output events.
  logic       l4_prev = 1'b0;
  logic [3:0] hit;
  always @(negedge clk) begin
    ev_t e;
    total++;
    if ((p4 & r4) !== 1'b0) begin
      bad++;
      $display("FAIL pulse_overlap cyc=%0d press=%b release=%b required not both high", cyc, p4, r4);
    end
    hit = {l4_prev & ~l4, ~l4_prev & l4, r4, p4};
    for (int k = 0; k < 4; k++) begin
      if (hit[k] === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_%s cyc=%0d observed event, required none", kname[k], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.cyc !== cyc) begin
            bad++;
            $display("FAIL event_%s observed %s@%0d required %s@%0d",
                     kname[k], kname[k], cyc, kname[e.kind], e.cyc);
          end else begin
            $display("event %s at cyc=%0d ok", kname[k], cyc);
          end
        end
      end
    end
    l4_prev = l4;
  end

  // Wait (bounded) for outstanding expected events; report how many remain.
  task automatic wait_idle(output int left);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int c, c2, n, pc, left;
    button_raw = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({b4, p4, r4, l4, b16, p16, r16, l16} !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got %b required 00000000",
                 cyc, {b4, p4, r4, l4, b16, p16, r16, l16});
      end
    end
    @(negedge clk);
    c = cyc;
    rst = 1'b1;
    exp_q.push_back('{0, c + 6});
    n = 0;
    pc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (p16) begin
        n++;
        pc = cyc;
      end
    end
    total++;
    if (n !== 1 || pc !== c + 18) begin
      bad++;
      $display("FAIL reset_requalify16 presses=%0d at cyc=%0d required 1 at %0d", n, pc, c + 18);
    end
    total++;
    if (b16 !== 1'b1) begin
      bad++;
      $display("FAIL reset_button16 got %b required 1", b16);
    end
    @(negedge clk);
    c2 = cyc;
    button_raw = 1'b0;
    exp_q.push_back('{1, c2 + 6});
    wait_idle(left);
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL reset_events_missing got %0d outstanding required 0", left);
    end
    repeat (20) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_bounce();
    int left;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      button_raw = (i % 2 == 0);
    end
    @(negedge clk);
    button_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (b4 !== 1'b0) begin
        bad++;
        $display("FAIL bounce_button cyc=%0d got %b required 0", cyc, b4);
      end
    end
    wait_idle(left);
    $display("test_bounce done");
  endtask

  task automatic test_clean_press();
    int c, left;
    @(negedge clk);
    c = cyc;
    button_raw = 1'b1;
    exp_q.push_back('{0, c + 6});
    repeat (5) @(negedge clk);
    total++;
    if (b4 !== 1'b0) begin
      bad++;
      $display("FAIL press_latency_early cyc=%0d got %b required 0", cyc, b4);
    end
    @(negedge clk);
    total++;
    if (b4 !== 1'b1) begin
      bad++;
      $display("FAIL press_latency cyc=%0d got %b required 1", cyc, b4);
    end
    wait_idle(left);
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL press_events_missing got %0d required 0", left);
    end
    $display("test_clean_press done");
  endtask

  task automatic test_release_bounce();
    int c, left;
    @(negedge clk);
    button_raw = 1'b0;
    repeat (2) @(negedge clk);
    button_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (b4 !== 1'b1) begin
        bad++;
        $display("FAIL release_bounce_button cyc=%0d got %b required 1", cyc, b4);
      end
    end
    @(negedge clk);
    c = cyc;
    button_raw = 1'b0;
    exp_q.push_back('{1, c + 6});
    repeat (5) @(negedge clk);
    total++;
    if (b4 !== 1'b1) begin
      bad++;
      $display("FAIL release_latency_early cyc=%0d got %b required 1", cyc, b4);
    end
    @(negedge clk);
    total++;
    if (b4 !== 1'b0) begin
      bad++;
      $display("FAIL release_latency cyc=%0d got %b required 0", cyc, b4);
    end
    wait_idle(left);
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL release_events_missing got %0d required 0", left);
    end
    $display("test_release_bounce done");
  endtask

  task automatic test_long_press();
    int c, c4, left;
    @(negedge clk);
    c = cyc;
    button_raw = 1'b1;
    exp_q.push_back('{0, c + 6});
    exp_q.push_back('{2, c + 106});
    repeat (110) @(negedge clk);
    total++;
    if ({b4, l4} !== 2'b11) begin
      bad++;
      $display("FAIL long_hold got button=%b long=%b required 1 1", b4, l4);
    end
    @(negedge clk);
    c4 = cyc;
    button_raw = 1'b0;
    exp_q.push_back('{1, c4 + 6});
    exp_q.push_back('{3, c4 + 6});
    repeat (5) @(negedge clk);
    total++;
    if (l4 !== 1'b1) begin
      bad++;
      $display("FAIL long_held_in_release_wait cyc=%0d got %b required 1", cyc, l4);
    end
    @(negedge clk);
    total++;
    if ({b4, l4} !== 2'b00) begin
      bad++;
      $display("FAIL long_clear cyc=%0d got button=%b long=%b required 0 0", cyc, b4, l4);
    end
    wait_idle(left);
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL long_events_missing got %0d required 0", left);
    end
    $display("test_long_press done");
  endtask

  task automatic test_integration();
    int cb, r0, left;
    r0 = rises;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      button_raw = (i % 2 == 0);
    end
    @(negedge clk);
    cb = cyc;
    button_raw = 1'b1;
    exp_q.push_back('{0, cb + 6});
    exp_q.push_back('{1, cb + 46});
    repeat (40) @(negedge clk);
    button_raw = 1'b0;
    wait_idle(left);
    repeat (5) @(negedge clk);
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL integ_events_missing got %0d required 0", left);
    end
    total++;
    if (rises - r0 !== 1) begin
      bad++;
      $display("FAIL integ_rising_edges got %0d required 1", rises - r0);
    end
    total++;
    if (throw_v < 1 || throw_v > 6) begin
      bad++;
      $display("FAIL integ_throw got %0d required 1..6", throw_v);
    end
    $display("test_integration done throw=%0d", throw_v);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_release_bounce();
    test_long_press();
    test_integration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d bench did not complete", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage directly upstream of the electronic dice FSM.
- Takes the raw, asynchronous, bouncy push-button input and synchronises it into clk.
- Debounces it with a consecutive-sample counter and drives a clean `button` level into the dice FSM's `button` input.
- Also produces one-cycle press/release pulses and a long-press flag for the display/score logic.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change; legal range ≥2.
- LONG_CYCLES, 50_000_000, cycles `button` must stay high before `long_press` asserts; legal range > DEBOUNCE_CYCLES.
- CNT_W, $clog2(LONG_CYCLES+1), width of the shared cycle counter (derived; not overridden).

Ports:
- clk  in  1  system clock; all flops on the rising edge
- rst  in  1  asynchronous, active-low reset
- button_raw  in  1  raw push-button level, asynchronous to clk, may bounce
- button  out  1  debounced level; connects to the dice FSM `button`
- press  out  1  one-cycle pulse on accepted 0→1 transition
- release  out  1  one-cycle pulse on accepted 1→0 transition
- long_press  out  1  high while held ≥ LONG_CYCLES after acceptance

Behaviour:
- Reset (rst=0, asynchronous): sync flops=0, state=RELEASED, cnt=0, button=0, press=0, release=0, long_press=0. Outputs are registered; no combinational path from button_raw.
- Synchroniser: two flops, sync0 <= button_raw, sync1 <= sync0. The FSM samples sync1 only.
- States are RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED:
  - sync1=1 → PRESS_WAIT, cnt<=1.
  - Otherwise stay, cnt<=0.
- PRESS_WAIT:
  - sync1=0 → RELEASED, cnt<=0 (bounce rejected).
  - sync1=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED, button<=1, press<=1, cnt<=0.
  - Otherwise cnt++.
- PRESSED:
  - sync1=0 → RELEASE_WAIT, cnt<=1. long_press is unchanged; it remains high until the release is accepted.
  - Otherwise cnt saturates at LONG_CYCLES.
  - long_press<=1 on the cycle cnt reaches LONG_CYCLES.
- RELEASE_WAIT:
  - sync1=1 → PRESSED with no press pulse. cnt resumes from 0; long_press is held if already set.
  - sync1=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED, button<=0, release<=1, long_press<=0, cnt<=0.
  - Otherwise cnt++.
- Pulses: press and release are high for exactly one cycle and are never simultaneously high.
- Latency: if button_raw is first captured high at edge k and stays stable, button rises after edge k+DEBOUNCE_CYCLES+1. Release is symmetric.
- Glitch rule: any raw pulse shorter than DEBOUNCE_CYCLES cycles never changes button and never generates press or release.
- Reset mid-operation: all state is cleared immediately. button_raw held high across reset de-assertion is re-qualified as a fresh press, producing a press pulse DEBOUNCE_CYCLES+2 edges later.
- cnt never wraps; it saturates at LONG_CYCLES.

Decomposition:
- Shared package dice_pkg holds:
  - the state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), 2 bits;
  - a DEFAULT_DEBOUNCE constant;
  - a DEFAULT_LONG constant, also reused by dice FSM timing.
- One natural sub-module: sync_2ff (generic two-flop synchroniser, async active-low reset, reset value 0). The FSM and counter stay in button_debounce.

Test Plan:
- Reset: rst=0 for 10 clk with button_raw=1 → button=0, press=0, release=0, long_press=0 throughout. After release of rst, press pulses once, 18 edges later (DEBOUNCE_CYCLES=16).
- Bounce rejection: toggle button_raw every cycle for 8 cycles, then hold 0 → button stays 0 and no press/release pulses.
- Clean press (DEBOUNCE_CYCLES=4): raw 0→1 captured at edge k and held → button=1 after edge k+5, press high exactly one cycle, release=0.
- Release with bounce (DEBOUNCE_CYCLES=4): while PRESSED, raw drops for 2 cycles then returns high → button stays 1, no pulses. Then raw 0 held → button=0 after 5 edges, single release pulse.
- Long press (LONG_CYCLES=100, DEBOUNCE_CYCLES=4): hold raw high → long_press rises 100 cycles after press. It clears on the same edge button falls after release.
- Integration: drive the dice FSM `button` from this block with a bouncy 8-cycle burst plus a 40-cycle hold → FSM sees a single rising edge, and throw stays in the range 1–6.
